pearson_msg_loader: RTL and testbench
=====================================

# pearson_msg_loader

Byte-stream front end for the Pearson hash stage. Accepts message bytes over a valid/ready stream, packs up to MSG_LEN bytes into a fixed-width message block padded with PAD_BYTE, and hands the block to the downstream hasher with a one-cycle start pulse. It then holds the block stable until the hasher reports done. It sits directly upstream of the hasher and replaces its hard-wired message constants.

## Interface
- MSG_LEN, 8: bytes per message block (2..16).
- PAD_BYTE, 8'h00: fill value for unused byte lanes.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- s_data  in  8  message byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  final byte of the message; qualified by s_valid.
- s_ready  out  1  loader accepts a byte this cycle.
- m_msg  out  8*MSG_LEN  packed block; byte i is m_msg[8i+7:8i], and byte 0 is the first byte received.
- m_len  out  $clog2(MSG_LEN+1)  number of valid bytes, 1..MSG_LEN.
- m_start  out  1  one-cycle pulse; the block is ready for the hasher.
- m_done  in  1  hasher finished with the block.
- err_trunc  out  8  saturating count of truncated messages (PEARSON_LOADER_ERR_EN only).

## Operation
- A byte is accepted on any edge where s_valid && s_ready.
- The FSM has four states: FILL, ISSUE, WAIT, DRAIN. Reset enters FILL.
- **FILL**
  - s_ready=1.
  - An accepted byte is written to lane cnt, then cnt increments.
  - Go to ISSUE when the accepted byte has s_last=1, or when cnt reaches MSG_LEN.
  - If cnt reaches MSG_LEN and s_last=0 on that byte, set the trunc flag.
- **ISSUE**
  - s_ready=0 and m_start=1 for exactly one cycle.
  - Next state is always WAIT.
- **WAIT**
  - s_ready=0.
  - On m_done=1: if the trunc flag is set, go to DRAIN. Otherwise clear the lanes to PAD_BYTE, set cnt=0, and go to FILL.
- **DRAIN**
  - s_ready=1; accepted bytes are discarded.
  - On an accepted s_last: clear the lanes to PAD_BYTE, set cnt=0, clear trunc, and go to FILL.
- Unwritten lanes always read PAD_BYTE.
- m_len = cnt, frozen from the transition into ISSUE until leaving WAIT.
- A message is at least one byte. s_last on the first byte gives m_len=1.
- m_done is ignored in FILL, ISSUE and DRAIN.
- Inputs are not checked for X. s_data and s_last are don't-care while s_valid=0.

## Timing
- Reset values:
  - s_ready=1, m_start=0.
  - m_msg = all lanes PAD_BYTE, m_len=0.
  - err_trunc=0, cnt=0, state=FILL.
- Latency: the last byte is accepted at edge N and m_start is high in the cycle after edge N, i.e. one cycle.
- m_msg and m_len are valid and stable whenever m_start=1 and throughout WAIT.
- Throughput: at most one byte per cycle.
- Minimum gap between blocks: ISSUE (1 cycle) + WAIT (at least 1 cycle).
- If m_done arrives in the first WAIT cycle, s_ready returns high 2 cycles after the last byte.
- s_ready is a registered function of state only. There is no combinational path from s_valid or m_done to s_ready.
- Reset asserted mid-message or in WAIT/DRAIN: the partial block is discarded and all outputs return to their reset values immediately. m_start is never emitted for that block.

## Configuration
- Macro: PEARSON_LOADER_ERR_EN.
- **With the macro:** err_trunc exists. It increments, saturating at 255, on each transition ISSUE→WAIT with trunc set.
- **Without the macro:** the err_trunc port and its counter are absent. Truncation behaviour (the block is issued with the first MSG_LEN bytes, the rest is dropped through DRAIN) is identical in both builds.

## Structure
- Shared package pearson_pkg holds:
  - the state typedef (FILL/ISSUE/WAIT/DRAIN);
  - the MSG_LEN default;
  - the PAD_BYTE default;
  - the length-width constant, which the hasher also uses.
- One sub-module, pearson_lane_buf: MSG_LEN×8 lane register with write-enable, lane index and synchronous clear-to-PAD_BYTE. The FSM, counter and error logic stay in the top module.

## Test plan
- **Full message:** stream 47,17,48,12,26,28,40,21 with s_last on 21, m_done 3 cycles after m_start. Expect m_msg=64'h15281C1A0C30112F, m_len=8, m_start high for one cycle, one cycle after the last byte. s_ready=0 until the edge after m_done.
- **Short message:** bytes 8'hAA,8'hBB with s_last, PAD_BYTE=0. Expect m_msg=64'h000000000000BBAA, m_len=2.
- **Truncation:** 10 bytes 1..10 with s_last on 10. Expect m_msg bytes 1..8 and m_len=8. Bytes 9,10 are accepted in DRAIN after m_done and discarded. With ERR_EN, err_trunc=1. The next message packs from lane 0.
- **Back-pressure and idle gaps:** random s_valid gaps, and s_valid held during WAIT. Expect no byte lost or duplicated, and s_ready=0 for all of ISSUE/WAIT.
- **Reset mid-fill:** assert reset after 3 of 8 bytes. Expect reset values on all outputs, no m_start, and a following 1-byte message giving m_len=1.
- **Spurious m_done:** pulse m_done during FILL. Expect no state change and a block issued normally afterwards.

Source files
------------

// File: rtl/pearson_pkg.sv
// Shared types and defaults for the Pearson hash front end and hasher.
package pearson_pkg;

    localparam int          MSG_LEN_DEF  = 8;
    localparam logic [7:0]  PAD_BYTE_DEF = 8'h00;
    localparam int          LEN_W        = $clog2(MSG_LEN_DEF + 1);

    // Encoded as plain constants so legacy code comparing raw state bits still works.
    typedef logic [1:0] state_t;
    localparam state_t FILL  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t DRAIN = 2'd3;

endpackage

// File: rtl/pearson_lane_buf.sv
// MSG_LEN x 8 lane register: one byte write per cycle, synchronous clear to PAD_BYTE.
module pearson_lane_buf
    import pearson_pkg::*;
#(
    parameter int         MSG_LEN  = MSG_LEN_DEF,
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]   idx,
    input  logic [7:0]                   data,
    input  logic                         clear,
    output logic [8*MSG_LEN-1:0]         msg
);

    logic [MSG_LEN-1:0][7:0] lanes;

    for (genvar i = 0; i < MSG_LEN; i++) begin : g_lane
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                lanes[i] <= PAD_BYTE;
            else if (clear)
                lanes[i] <= PAD_BYTE;
            else if (wr_en && idx == ($clog2(MSG_LEN))'(i))
                lanes[i] <= data;
        end
    end

    assign msg = lanes;

endmodule

// File: rtl/pearson_msg_loader.sv
// Packs a byte stream into a padded message block and hands it to the Pearson hasher.
// Optional truncation counter (err_trunc) is built when PEARSON_LOADER_ERR_EN is defined.
module pearson_msg_loader
    import pearson_pkg::*;
#(
    parameter int         MSG_LEN  = MSG_LEN_DEF,
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     s_data,
    input  logic                           s_valid,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic [8*MSG_LEN-1:0]           m_msg,
    output logic [$clog2(MSG_LEN+1)-1:0]   m_len,
    output logic                           m_start,
    input  logic                           m_done
`ifdef PEARSON_LOADER_ERR_EN
    ,
    output logic [7:0]                     err_trunc
`endif
);

    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int IW = $clog2(MSG_LEN);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           trunc;
    logic           accept, full_hit, wr_en, clear;

    // Outputs decode registered state only, so no input reaches s_ready combinationally.
    assign s_ready  = (state == FILL) || (state == DRAIN);
    assign m_start  = (state == ISSUE);
    assign m_len    = cnt;

    assign accept   = s_valid && s_ready;
    assign full_hit = (cnt == CW'(MSG_LEN - 1));
    assign wr_en    = (state == FILL) && accept;
    assign clear    = ((state == WAIT) && m_done && !trunc) ||
                      ((state == DRAIN) && accept && s_last);

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && (s_last || full_hit)) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (m_done) state_nxt = trunc ? DRAIN : FILL;
            DRAIN:   if (accept && s_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
            trunc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear)
                cnt <= '0;
            else if (wr_en)
                cnt <= cnt + 1'b1;
            // Block filled without seeing s_last: the tail must be drained after the hasher is done.
            if (wr_en && full_hit && !s_last)
                trunc <= 1'b1;
            else if ((state == DRAIN) && accept && s_last)
                trunc <= 1'b0;
        end
    end

`ifdef PEARSON_LOADER_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_trunc <= 8'd0;
        else if ((state == ISSUE) && trunc && (err_trunc != 8'hFF))
            err_trunc <= err_trunc + 8'd1;
    end
`endif

    pearson_lane_buf #(
        .MSG_LEN  (MSG_LEN),
        .PAD_BYTE (PAD_BYTE)
    ) u_lane_buf (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .idx   (cnt[IW-1:0]),
        .data  (s_data),
        .clear (clear),
        .msg   (m_msg)
    );

endmodule

// File: tb/tb_pearson_msg_loader.sv
// Directed bench for pearson_msg_loader (MSG_LEN=8, PAD_BYTE=0); inputs driven and outputs sampled on negedge.
module tb_pearson_msg_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [63:0] m_msg;
    logic [3:0]  m_len;
    logic        m_start, m_done;
`ifdef PEARSON_LOADER_ERR_EN
    logic [7:0]  err_trunc;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pearson_msg_loader #(.MSG_LEN(8), .PAD_BYTE(8'h00)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_msg    (m_msg),
        .m_len    (m_len),
        .m_start  (m_start),
        .m_done   (m_done)
`ifdef PEARSON_LOADER_ERR_EN
        ,
        .err_trunc(err_trunc)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic push(input logic [7:0] d, input logic last);
        int n = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 64'(n), 64'd0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic done_blk();
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bad;
        int starts;
        reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_done = 1'b0;
        idle(2);
        chk("rst_ready", 64'(s_ready), 64'd1);
        chk("rst_start", 64'(m_start), 64'd0);
        chk("rst_msg",   m_msg, 64'd0);
        chk("rst_len",   64'(m_len), 64'd0);
`ifdef PEARSON_LOADER_ERR_EN
        chk("rst_err",   64'(err_trunc), 64'd0);
`endif
        reset = 1'b0;
        idle(1);

        // Full message, m_done three cycles after m_start
        push(8'd47, 0); push(8'd17, 0); push(8'd48, 0); push(8'd12, 0);
        push(8'd26, 0); push(8'd28, 0); push(8'd40, 0); push(8'd21, 1);
        chk("full_start", 64'(m_start), 64'd1);
        chk("full_msg",   m_msg, 64'h15281C1A0C30112F);
        chk("full_len",   64'(m_len), 64'd8);
        chk("full_rdy0",  64'(s_ready), 64'd0);
        idle(1);
        chk("full_pulse", 64'(m_start), 64'd0);
        chk("full_hold",  m_msg, 64'h15281C1A0C30112F);
        idle(2);
        chk("full_wrdy",  64'(s_ready), 64'd0);
        done_blk();
        chk("full_rdy1",  64'(s_ready), 64'd1);
        chk("full_clr",   m_msg, 64'd0);
        chk("full_len0",  64'(m_len), 64'd0);

        // Short message, m_done in first WAIT cycle
        push(8'hAA, 0); push(8'hBB, 1);
        chk("short_msg", m_msg, 64'h000000000000BBAA);
        chk("short_len", 64'(m_len), 64'd2);
        idle(1);
        done_blk();
        chk("short_rdy", 64'(s_ready), 64'd1);

        // Truncation: 10 bytes into an 8-byte block
        for (int i = 1; i <= 8; i++) push(8'(i), 0);
        chk("trunc_start", 64'(m_start), 64'd1);
        chk("trunc_msg",   m_msg, 64'h0807060504030201);
        chk("trunc_len",   64'(m_len), 64'd8);
        idle(1);
        done_blk();
        chk("trunc_drain_rdy", 64'(s_ready), 64'd1);
        push(8'd9, 0);
        chk("trunc_no_start", 64'(m_start), 64'd0);
        push(8'd10, 1);
        chk("trunc_start2", 64'(m_start), 64'd0);
        chk("trunc_clr",    m_msg, 64'd0);
`ifdef PEARSON_LOADER_ERR_EN
        chk("trunc_err",    64'(err_trunc), 64'd1);
`endif
        push(8'h5A, 1);
        chk("trunc_next_msg", m_msg, 64'h5A);
        chk("trunc_next_len", 64'(m_len), 64'd1);
        idle(1);
        done_blk();

        // Back-pressure with idle gaps, then s_valid held through ISSUE/WAIT
        for (int i = 1; i <= 5; i++) begin
            idle($urandom_range(0, 3));
            push(8'hC0 + 8'(i), i == 5);
        end
        chk("bp_msg", m_msg, 64'h000000C5C4C3C2C1);
        chk("bp_len", 64'(m_len), 64'd5);
        s_data = 8'hD1; s_last = 1'b1; s_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (s_ready) bad++;
            if (i < 2) @(negedge clk);
        end
        chk("bp_rdy_low", 64'(bad), 64'd0);
        chk("bp_hold_msg", m_msg, 64'h000000C5C4C3C2C1);
        done_blk();
        @(negedge clk);
        s_valid = 1'b0;
        chk("bp_next_start", 64'(m_start), 64'd1);
        chk("bp_next_msg",   m_msg, 64'hD1);
        chk("bp_next_len",   64'(m_len), 64'd1);
        idle(1);
        done_blk();

        // Reset mid-fill
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
        reset = 1'b1;
        #1;
        chk("mrst_ready", 64'(s_ready), 64'd1);
        chk("mrst_start", 64'(m_start), 64'd0);
        chk("mrst_msg",   m_msg, 64'd0);
        chk("mrst_len",   64'(m_len), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_start) starts++;
            @(negedge clk);
        end
        chk("mrst_nostart", 64'(starts), 64'd0);
        push(8'h77, 1);
        chk("mrst_one_msg", m_msg, 64'h77);
        chk("mrst_one_len", 64'(m_len), 64'd1);
        idle(1);
        done_blk();

        // Spurious m_done during FILL
        push(8'h11, 0); push(8'h22, 0);
        done_blk();
        chk("spur_rdy", 64'(s_ready), 64'd1);
        chk("spur_len", 64'(m_len), 64'd2);
        push(8'h33, 1);
        chk("spur_start", 64'(m_start), 64'd1);
        chk("spur_msg",   m_msg, 64'h332211);
        chk("spur_len3",  64'(m_len), 64'd3);
        idle(1);
        done_blk();
        chk("spur_end_rdy", 64'(s_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
